// File: rtl/dram_rd_capture_if.sv
// rtl/dram_rd_capture_if.sv - read-queue beat handshake between capture FIFO and DRAM controller
interface dram_rd_capture_if;
    logic         rdq_valid;
    logic         rdq_ready;
    logic [255:0] rdq_data;
    logic [31:0]  rdq_ecc;
    logic         rdq_last;

    modport master (
        output rdq_valid,
        output rdq_data,
        output rdq_ecc,
        output rdq_last,
        input  rdq_ready
    );

    modport slave (
        input  rdq_valid,
        input  rdq_data,
        input  rdq_ecc,
        input  rdq_last,
        output rdq_ready
    );
endinterface

// File: rtl/dram_rd_capture.sv
// rtl/dram_rd_capture.sv - DDR read-return capture register, line phase tagging and beat FIFO; DRAM_RD_CAPTURE_CNT_EN adds a saturating line counter
module dram_rd_capture #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               rclk,
    input  logic               arst_l,
    input  logic [255:0]       io_dram_data_in,
    input  logic [31:0]        io_dram_ecc_in,
    input  logic               io_dram_data_valid,
    input  logic               dram_io_channel_disabled,
    dram_rd_capture_if.master  rdq,
    output logic               rdq_ovf_err,
    input  logic               rdq_ovf_clr,
`ifdef DRAM_RD_CAPTURE_CNT_EN
    output logic [15:0]        rdq_line_cnt,
`endif
    output logic [PTR_W:0]     rdq_level
);

    localparam int            CW       = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [255:0]     cap_data;
    logic [31:0]      cap_ecc;
    logic             cap_vld;

    logic [255:0]     mem_data [DEPTH];
    logic [31:0]      mem_ecc  [DEPTH];
    logic [DEPTH-1:0] mem_last;

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CW-1:0]    count;
    logic             phase;

    logic             wr_req;
    logic             rd;
    logic             full;
    logic             wr;
    logic             ovf;

    // Pad outputs are retimed once before they touch the FIFO.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            cap_data <= '0;
            cap_ecc  <= '0;
            cap_vld  <= 1'b0;
        end else begin
            cap_data <= io_dram_data_in;
            cap_ecc  <= io_dram_ecc_in;
            cap_vld  <= io_dram_data_valid;
        end
    end

    always_comb begin
        wr_req = cap_vld & ~dram_io_channel_disabled;
        rd     = rdq.rdq_valid & rdq.rdq_ready;
        full   = (count == FULL_CNT);
        wr     = wr_req & (~full | rd);
        ovf    = wr_req & full & ~rd;
    end

    always_ff @(posedge rclk) begin
        if (wr) begin
            mem_data[wptr] <= cap_data;
            mem_ecc[wptr]  <= cap_ecc;
            mem_last[wptr] <= phase;
        end
    end

    // Phase follows every offered beat, dropped or not, so a lost beat never shifts line alignment.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            phase <= 1'b0;
        end else if (dram_io_channel_disabled) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            phase <= 1'b0;
        end else begin
            if (wr) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (rd) begin
                rptr <= rptr + PTR_W'(1);
            end
            count <= count + CW'(wr) - CW'(rd);
            if (wr_req) begin
                phase <= ~phase;
            end
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            rdq_ovf_err <= 1'b0;
        end else if (ovf) begin
            rdq_ovf_err <= 1'b1;
        end else if (rdq_ovf_clr) begin
            rdq_ovf_err <= 1'b0;
        end
    end

`ifdef DRAM_RD_CAPTURE_CNT_EN
    logic [15:0] line_cnt;

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            line_cnt <= '0;
        end else if (wr && phase && (line_cnt != 16'hFFFF)) begin
            line_cnt <= line_cnt + 16'd1;
        end
    end

    assign rdq_line_cnt = line_cnt;
`endif

    // Storage is unreset, so the head mux forces zeros whenever the queue is empty.
    always_comb begin
        rdq.rdq_valid = (count != '0);
        rdq.rdq_data  = rdq.rdq_valid ? mem_data[rptr] : '0;
        rdq.rdq_ecc   = rdq.rdq_valid ? mem_ecc[rptr]  : '0;
        rdq.rdq_last  = rdq.rdq_valid ? mem_last[rptr] : 1'b0;
        rdq_level     = count;
    end

endmodule

// File: tb/tb_dram_rd_capture.sv
// tb/tb_dram_rd_capture.sv - randomized self-checking bench for dram_rd_capture against a queue model
module tb_dram_rd_capture;

    logic         rclk = 1'b0;
    logic         arst_l;
    logic [255:0] in_d;
    logic [31:0]  in_e;
    logic         in_v;
    logic         dis;
    logic         clr;
    logic         ovf_err;
    logic [2:0]   level;
`ifdef DRAM_RD_CAPTURE_CNT_EN
    logic [15:0]  line_cnt;
`endif

    always #5 rclk = ~rclk;

    dram_rd_capture_if rdq_if ();

    dram_rd_capture dut (
        .rclk                     (rclk),
        .arst_l                   (arst_l),
        .io_dram_data_in          (in_d),
        .io_dram_ecc_in           (in_e),
        .io_dram_data_valid       (in_v),
        .dram_io_channel_disabled (dis),
        .rdq                      (rdq_if),
        .rdq_ovf_err              (ovf_err),
        .rdq_ovf_clr              (clr),
`ifdef DRAM_RD_CAPTURE_CNT_EN
        .rdq_line_cnt             (line_cnt),
`endif
        .rdq_level                (level)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [255:0] d;
        logic [31:0]  e;
        logic         l;
    } beat_t;

    // Reference: a beat queue of capacity 4, a one-beat input delay, a line phase bit.
    beat_t        q[$];
    logic         m_cap_v;
    logic [255:0] m_cap_d;
    logic [31:0]  m_cap_e;
    logic         m_phase;
    logic         m_ovf;
    int           m_cnt;

    wire [293:0] dut_out = {rdq_if.rdq_valid, level, rdq_if.rdq_last, ovf_err,
                            rdq_if.rdq_data, rdq_if.rdq_ecc};

    function automatic logic [293:0] exp_out();
        beat_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        return {q.size() != 0, 3'(q.size()), h.l, m_ovf, h.d, h.e};
    endfunction

    task automatic model_reset();
        q.delete();
        m_cap_v = 1'b0;
        m_cap_d = '0;
        m_cap_e = '0;
        m_phase = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic cycle();
        bit    rd;
        bit    full;
        bit    set;
        beat_t tmp;
        rd   = (q.size() != 0) && (rdq_if.rdq_ready === 1'b1);
        full = (q.size() == 4);
        @(posedge rclk);
        set = 1'b0;
        if (dis) begin
            q.delete();
            m_phase = 1'b0;
        end else begin
            if (rd) tmp = q.pop_front();
            if (m_cap_v) begin
                if (full && !rd) begin
                    set = 1'b1;
                end else begin
                    q.push_back({m_cap_d, m_cap_e, m_phase});
                    if (m_phase && m_cnt < 65535) m_cnt++;
                end
                m_phase = ~m_phase;
            end
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_cap_v = in_v;
        m_cap_d = in_d;
        m_cap_e = in_e;
        #1;
    endtask

    task automatic rand_beat();
        in_v = 1'b1;
        for (int i = 0; i < 8; i++) in_d[i*32 +: 32] = $urandom;
        in_e = $urandom;
    endtask

    task automatic apply_reset();
        arst_l = 1'b0;
        in_v = 1'b0; in_d = '0; in_e = '0; dis = 1'b0; clr = 1'b0;
        rdq_if.rdq_ready = 1'b0;
        model_reset();
        @(negedge rclk);
        @(negedge rclk);
        arst_l = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        arst_l = 1'b0;
        in_v = 1'b0; in_d = '0; in_e = '0; dis = 1'b0; clr = 1'b0;
        rdq_if.rdq_ready = 1'b0;
        model_reset();
        #3;
        checks++;
        if (dut_out !== 294'd0) begin
            errors++;
            $display("FAIL reset_state: got %h required 0", dut_out);
        end
        @(negedge rclk);
        arst_l = 1'b1;
        cycle();
        checks++;
        if (dut_out !== exp_out()) begin
            errors++;
            $display("FAIL reset_release: got %h required %h", dut_out, exp_out());
        end
    endtask

    task automatic test_basic();
        rdq_if.rdq_ready = 1'b1;
        in_v = 1'b1; in_d = 256'h1; in_e = 32'hA;
        cycle();
        checks++;
        if (rdq_if.rdq_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1: valid got %b required 0", rdq_if.rdq_valid);
        end
        in_v = 1'b1; in_d = 256'h2; in_e = 32'hB;
        cycle();
        checks++;
        if ({rdq_if.rdq_valid, rdq_if.rdq_data, rdq_if.rdq_ecc, rdq_if.rdq_last} !==
            {1'b1, 256'h1, 32'hA, 1'b0}) begin
            errors++;
            $display("FAIL basic_beat0: got v=%b d=%h e=%h l=%b", rdq_if.rdq_valid,
                     rdq_if.rdq_data, rdq_if.rdq_ecc, rdq_if.rdq_last);
        end
        in_v = 1'b0;
        cycle();
        checks++;
        if ({rdq_if.rdq_valid, rdq_if.rdq_data, rdq_if.rdq_ecc, rdq_if.rdq_last} !==
            {1'b1, 256'h2, 32'hB, 1'b1}) begin
            errors++;
            $display("FAIL basic_beat1: got v=%b d=%h e=%h l=%b", rdq_if.rdq_valid,
                     rdq_if.rdq_data, rdq_if.rdq_ecc, rdq_if.rdq_last);
        end
        cycle();
        checks++;
        if (level !== 3'd0 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL basic_drained: got %h required %h", dut_out, exp_out());
        end
    endtask

    task automatic test_overflow();
        logic [255:0] sent [6];
        rdq_if.rdq_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            sent[i] = in_d;
            cycle();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("FAIL ovf_fill%0d: got %h required %h", i, dut_out, exp_out());
            end
        end
        in_v = 1'b0;
        cycle();
        cycle();
        checks++;
        if (level !== 3'd4 || ovf_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_full: level got %0d required 4, ovf got %b required 1", level, ovf_err);
        end
        rdq_if.rdq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rdq_if.rdq_data !== sent[i] || rdq_if.rdq_last !== 1'(i % 2)) begin
                errors++;
                $display("FAIL ovf_drain%0d: got d=%h l=%b required d=%h l=%0d", i,
                         rdq_if.rdq_data, rdq_if.rdq_last, sent[i], i % 2);
            end
            cycle();
        end
        checks++;
        if (dut_out !== exp_out()) begin
            errors++;
            $display("FAIL ovf_after_drain: got %h required %h", dut_out, exp_out());
        end
        rdq_if.rdq_ready = 1'b0;
    endtask

    task automatic test_ovf_clr();
        rdq_if.rdq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            cycle();
        end
        in_v = 1'b0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checks++;
        if (ovf_err !== 1'b1 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL ovf_set_wins: ovf got %b required 1", ovf_err);
        end
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        checks++;
        if (ovf_err !== 1'b0 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL ovf_clear: ovf got %b required 0", ovf_err);
        end
        rdq_if.rdq_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        checks++;
        if (dut_out !== exp_out()) begin
            errors++;
            $display("FAIL ovf_clr_drain: got %h required %h", dut_out, exp_out());
        end
        rdq_if.rdq_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        rdq_if.rdq_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_beat();
            cycle();
        end
        rdq_if.rdq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            cycle();
            checks++;
            if (level !== 3'd4 || ovf_err !== 1'b0 || dut_out !== exp_out()) begin
                errors++;
                $display("FAIL wrap_steady%0d: got %h required %h", i, dut_out, exp_out());
            end
        end
        in_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                $display("FAIL wrap_drain%0d: got %h required %h", i, dut_out, exp_out());
            end
        end
        rdq_if.rdq_ready = 1'b0;
    endtask

    task automatic test_disable();
        apply_reset();
        rand_beat();
        cycle();
        in_v = 1'b0;
        cycle();
        dis = 1'b1;
        cycle();
        dis = 1'b0;
        checks++;
        if (rdq_if.rdq_valid !== 1'b0 || level !== 3'd0 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL disable_flush: valid got %b level got %0d required 0/0",
                     rdq_if.rdq_valid, level);
        end
        rand_beat();
        cycle();
        in_v = 1'b0;
        cycle();
        checks++;
        if (rdq_if.rdq_valid !== 1'b1 || rdq_if.rdq_last !== 1'b0 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL disable_phase: valid got %b last got %b required 1/0",
                     rdq_if.rdq_valid, rdq_if.rdq_last);
        end
        rdq_if.rdq_ready = 1'b1;
        cycle();
        rdq_if.rdq_ready = 1'b0;
    endtask

    task automatic test_reset_midline();
        rand_beat();
        cycle();
        in_v = 1'b0;
        cycle();
        #2;
        arst_l = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_out !== 294'd0) begin
            errors++;
            $display("FAIL reset_midline: got %h required 0", dut_out);
        end
        @(negedge rclk);
        arst_l = 1'b1;
        cycle();
        rand_beat();
        cycle();
        in_v = 1'b0;
        cycle();
        checks++;
        if (rdq_if.rdq_last !== 1'b0 || rdq_if.rdq_valid !== 1'b1 || dut_out !== exp_out()) begin
            errors++;
            $display("FAIL reset_midline_phase: last got %b valid got %b required 0/1",
                     rdq_if.rdq_last, rdq_if.rdq_valid);
        end
        rdq_if.rdq_ready = 1'b1;
        cycle();
        rdq_if.rdq_ready = 1'b0;
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) != 0) rand_beat();
            else in_v = 1'b0;
            rdq_if.rdq_ready = ($urandom_range(2, 0) != 0);
            clr = ($urandom_range(15, 0) == 0);
            dis = ($urandom_range(39, 0) == 0);
            cycle();
            checks++;
            if (dut_out !== exp_out()) begin
                errors++;
                if (bad < 8) $display("FAIL random%0d: got %h required %h", i, dut_out, exp_out());
                bad++;
            end
        end
        in_v = 1'b0; clr = 1'b0; dis = 1'b0; rdq_if.rdq_ready = 1'b0;
    endtask

`ifdef DRAM_RD_CAPTURE_CNT_EN
    task automatic test_line_cnt();
        apply_reset();
        rdq_if.rdq_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin rand_beat(); cycle(); end
        in_v = 1'b0;
        cycle();
        cycle();
        rdq_if.rdq_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin rand_beat(); cycle(); end
        in_v = 1'b0;
        cycle();
        checks++;
        if (line_cnt !== 16'd3 || 32'(line_cnt) !== m_cnt) begin
            errors++;
            $display("FAIL line_cnt: got %0d required 3", line_cnt);
        end
        force dut.line_cnt = 16'hFFFF;
        #1;
        release dut.line_cnt;
        m_cnt = 65535;
        rdq_if.rdq_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin rand_beat(); cycle(); end
        in_v = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        checks++;
        if (line_cnt !== 16'hFFFF || 32'(line_cnt) !== m_cnt) begin
            errors++;
            $display("FAIL line_cnt_sat: got %h required ffff", line_cnt);
        end
        rdq_if.rdq_ready = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ovf_clr();
        test_full_wrap();
        test_disable();
        test_reset_midline();
        test_random();
`ifdef DRAM_RD_CAPTURE_CNT_EN
        test_line_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_rd_capture.md
Name: dram_rd_capture

Overview:
- Controller-side receiver for the read-data return path of a DDR pad channel.
- Samples the pad block's 256-bit data and 32-bit ECC beats while the data-valid strobe is high.
- Pairs consecutive beats into one 64-byte line and buffers up to 4 beats in a FIFO.
- Presents beats to the DRAM controller's read queue with a valid/ready handshake. Sits between the pad channel's data-in outputs and the DRAM controller.

Parameters:
- DEPTH, 4, FIFO entries, each one 288-bit beat (data plus ECC); power of two, minimum 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- rclk  in  1  cluster clock from the pad clock header; all logic on rising edge.
- arst_l  in  1  asynchronous active-low reset; assert async, deassert sync to rclk externally.
- io_dram_data_in  in  256  read data beat from pad.
- io_dram_ecc_in  in  32  ECC for the beat.
- io_dram_data_valid  in  1  beat present this cycle.
- dram_io_channel_disabled  in  1  channel off; flush and ignore input.
- rdq_ready  in  1  consumer accepts the head beat this cycle.
- rdq_valid  out  1  head beat valid.
- rdq_data  out  256  head beat data.
- rdq_ecc  out  32  head beat ECC.
- rdq_last  out  1  head beat is the second beat of a line.
- rdq_ovf_err  out  1  sticky overflow error flag.
- rdq_ovf_clr  in  1  clears rdq_ovf_err.
- rdq_level  out  PTR_W+1  current FIFO occupancy.

Behaviour:
- Reset (arst_l=0): wptr=rptr=0, count=0, beat phase=0, rdq_valid=0, rdq_last=0, rdq_ovf_err=0, rdq_level=0. rdq_data/rdq_ecc are 0 (FIFO storage is not reset; output muxes force 0 when empty).
- Capture register stage:
  - io_dram_* is registered on every rclk into cap_data, cap_ecc and cap_vld.
  - The FIFO write uses the registered values.
  - Latency from a valid input beat to rdq_valid is 2 cycles when the FIFO is empty.
- Line phase:
  - A 1-bit phase toggles on each accepted beat write.
  - The beat written while phase=1 is tagged last=1; the tag is stored per entry.
  - A line is always exactly 2 beats (burst length four, 128-bit bus).
- FIFO:
  - Write when cap_vld & ~channel_disabled. Read when rdq_valid & rdq_ready.
  - count updates as count+wr-rd.
  - rdq_valid = (count!=0).
  - Head entry drives rdq_data, rdq_ecc and rdq_last combinationally.
- Full with write and no read: the beat is dropped, rdq_ovf_err is set, and phase still toggles so later lines stay aligned. count and wptr are unchanged.
- Full with simultaneous read and write: both occur, no overflow, count unchanged.
- Empty with simultaneous write: write only; the new beat appears at the head the next cycle (no bypass).
- Pointer wrap: pointers wrap modulo DEPTH; full = (count==DEPTH).
- rdq_ovf_clr:
  - Clears the flag next cycle.
  - If an overflow occurs in the same cycle, set wins.
- dram_io_channel_disabled=1:
  - Next cycle: count=0, wptr=rptr=0, phase=0, rdq_valid=0.
  - cap_vld is ignored while disabled; rdq_ovf_err is kept.
  - Deasserting it resumes normal capture next cycle.
- Reset asserted mid-line: all state returns to reset values immediately. A partial line is lost and the next beat is treated as phase 0.

Optional Feature:
- Macro name: DRAM_RD_CAPTURE_CNT_EN.
- When defined:
  - Adds output rdq_line_cnt[15:0], a saturating count of lines written to the FIFO.
  - It increments on a write with last=1 and not dropped, holds at 16'hFFFF, and is reset to 0 by arst_l.
  - Channel disable does not clear it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then two valid beats (D0=256'h1, E0=32'hA; D1=256'h2, E1=32'hB) with rdq_ready=1:
  - rdq_valid rises 2 cycles after D0.
  - Outputs D0/A/last=0, then D1/B/last=1.
  - rdq_level ends 0.
- rdq_ready=0 and 6 consecutive beats:
  - rdq_level saturates at 4; beats 5 and 6 are dropped; rdq_ovf_err=1.
  - Draining yields beats 1-4 in order with last pattern 0,1,0,1.
- FIFO full at count=4, then rdq_ready=1 with valid input for 8 cycles: no overflow, level stays 4, output order preserved across pointer wrap.
- After beat 1 of a line, assert dram_io_channel_disabled for 1 cycle:
  - rdq_valid=0, rdq_level=0.
  - The next beat after release carries last=0.
- rdq_ovf_err=1, then rdq_ovf_clr pulse coincident with a new overflow: flag stays 1. A clear pulse alone drives it to 0.
- With DRAM_RD_CAPTURE_CNT_EN defined, write 3 complete lines plus one dropped last beat: rdq_line_cnt=3. Preloading the counter to FFFF via a forced value and adding one more line leaves it at FFFF.
